// File: rtl/emu_doppler_nco_pkg.sv
// Shared constants, sample type and quarter-wave magnitude table for the Doppler NCO.
package emu_doppler_nco_pkg;

  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 8;
  localparam int OUT_W   = 6;
  localparam int MAG_W   = 5;
  localparam int QTR_N   = 64;
  localparam int AMP     = 31;
  localparam int LATENCY = 3;

  typedef logic signed [OUT_W-1:0] sample_t;

  // round(31*sin(2*pi*i/256)) for i = 0..63; the 90-degree point (31) is not stored.
  localparam logic [MAG_W-1:0] QTR_TABLE [QTR_N] = '{
    5'd0,  5'd1,  5'd2,  5'd2,  5'd3,  5'd4,  5'd5,  5'd5,
    5'd6,  5'd7,  5'd8,  5'd8,  5'd9,  5'd10, 5'd10, 5'd11,
    5'd12, 5'd13, 5'd13, 5'd14, 5'd15, 5'd15, 5'd16, 5'd17,
    5'd17, 5'd18, 5'd18, 5'd19, 5'd20, 5'd20, 5'd21, 5'd21,
    5'd22, 5'd22, 5'd23, 5'd23, 5'd24, 5'd24, 5'd25, 5'd25,
    5'd26, 5'd26, 5'd27, 5'd27, 5'd27, 5'd28, 5'd28, 5'd28,
    5'd29, 5'd29, 5'd29, 5'd29, 5'd30, 5'd30, 5'd30, 5'd30,
    5'd30, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31
  };

endpackage

// File: rtl/emu_doppler_nco_lut.sv
// Phase address to signed cos/sin: stage 2 folds the quadrant and reads the table,
// stage 3 applies the sign. Outputs hold unless stage 3 is enabled.
module emu_doppler_nco_lut
  import emu_doppler_nco_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s1_vld,
  input  logic              s2_vld,
  input  logic [ADDR_W-1:0] addr,
  output sample_t           real_out,
  output sample_t           imag_out
);

  logic [5:0]       idx;
  logic [5:0]       cos_idx;
  logic [MAG_W-1:0] sin_tab;
  logic [MAG_W-1:0] cos_tab;

  logic [MAG_W-1:0] re_mag_q, re_mag_d;
  logic [MAG_W-1:0] im_mag_q, im_mag_d;
  logic             re_neg_q, re_neg_d;
  logic             im_neg_q, im_neg_d;
  sample_t          real_q, real_d;
  sample_t          imag_q, imag_d;

  // cos(j) = sin(64-j); j=0 lands on the unstored quarter point, so force full scale.
  always_comb begin
    idx     = addr[5:0];
    cos_idx = 6'd0 - idx;
    sin_tab = QTR_TABLE[idx];
    cos_tab = (idx == 6'd0) ? MAG_W'(AMP) : QTR_TABLE[cos_idx];
  end

  // Odd quadrants swap the roles of the two magnitudes; signs follow the quadrant.
  always_comb begin
    re_mag_d = re_mag_q;
    im_mag_d = im_mag_q;
    re_neg_d = re_neg_q;
    im_neg_d = im_neg_q;
    if (s1_vld) begin
      re_mag_d = addr[6] ? sin_tab : cos_tab;
      im_mag_d = addr[6] ? cos_tab : sin_tab;
      re_neg_d = addr[7] ^ addr[6];
      im_neg_d = addr[7];
    end
  end

  always_comb begin
    real_d = real_q;
    imag_d = imag_q;
    if (s2_vld) begin
      real_d = re_neg_q ? -sample_t'({1'b0, re_mag_q}) : sample_t'({1'b0, re_mag_q});
      imag_d = im_neg_q ? -sample_t'({1'b0, im_mag_q}) : sample_t'({1'b0, im_mag_q});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      re_mag_q <= '0;
      im_mag_q <= '0;
      re_neg_q <= 1'b0;
      im_neg_q <= 1'b0;
      real_q   <= '0;
      imag_q   <= '0;
    end else begin
      re_mag_q <= re_mag_d;
      im_mag_q <= im_mag_d;
      re_neg_q <= re_neg_d;
      im_neg_q <= im_neg_d;
      real_q   <= real_d;
      imag_q   <= imag_d;
    end
  end

  assign real_out = real_q;
  assign imag_out = imag_q;

endmodule

// File: rtl/emu_doppler_nco.sv
// Doppler NCO: 32-bit phase accumulator stepped per strobe, 3-cycle pipeline to a
// 6-bit complex carrier sample. Accepts a strobe every cycle; no backpressure.
module emu_doppler_nco
  import emu_doppler_nco_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               dv_in,
  input  logic [PHASE_W-1:0] freq,
  output logic               dv_out,
  output logic [OUT_W-1:0]   real_out,
  output logic [OUT_W-1:0]   imag_out
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  sample_t            lut_real;
  sample_t            lut_imag;

  // The sample uses the phase before this strobe's increment.
  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    vld_d   = {vld_q[LATENCY-2:0], dv_in};
    if (dv_in) begin
      phase_d = phase_q + freq;
      addr_d  = phase_q[PHASE_W-1 -: ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      addr_q  <= '0;
      vld_q   <= '0;
    end else begin
      phase_q <= phase_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
    end
  end

  emu_doppler_nco_lut u_lut (
    .clk      (clk),
    .reset    (reset),
    .s1_vld   (vld_q[0]),
    .s2_vld   (vld_q[1]),
    .addr     (addr_q),
    .real_out (lut_real),
    .imag_out (lut_imag)
  );

  assign dv_out   = vld_q[LATENCY-1];
  assign real_out = lut_real;
  assign imag_out = lut_imag;

endmodule

// File: tb/tb_emu_doppler_nco.sv
// Directed bench for emu_doppler_nco: scoreboard of hand-computed samples plus latency.
module tb_emu_doppler_nco;

  logic        clk;
  logic        reset;
  logic        dv_in;
  logic [31:0] freq;
  logic        dv_out;
  logic [5:0]  real_out;
  logic [5:0]  imag_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_re[$];
  int exp_im[$];
  int iss[$];

  emu_doppler_nco dut (
    .clk      (clk),
    .reset    (reset),
    .dv_in    (dv_in),
    .freq     (freq),
    .dv_out   (dv_out),
    .real_out (real_out),
    .imag_out (imag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare every dv_out pulse against the oldest expected sample.
  initial begin
    int r;
    int i;
    int t;
    forever begin
      @(posedge clk);
      #1;
      if (dv_out === 1'b1) begin
        if (exp_re.size() == 0) begin
          chk("spurious_dv_out", 1, 0);
        end else begin
          r = exp_re.pop_front();
          i = exp_im.pop_front();
          t = iss.pop_front();
          chk("real", int'($signed(real_out)), r);
          chk("imag", int'($signed(imag_out)), i);
          chk("latency", cyc - t, 3);
        end
        chk("no_minus32", int'(real_out == 6'h20 || imag_out == 6'h20), 0);
      end
    end
  end

  task automatic strobe(input logic [31:0] f, input int re, input int im);
    @(posedge clk);
    #1;
    dv_in = 1'b1;
    freq  = f;
    exp_re.push_back(re);
    exp_im.push_back(im);
    iss.push_back(cyc);
  endtask

  task automatic raw(input logic v, input logic [31:0] f, input logic r);
    @(posedge clk);
    #1;
    dv_in = v;
    freq  = f;
    reset = r;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      dv_in = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_re.size() != 0; k++) begin
      @(posedge clk);
      #3;
    end
    if (exp_re.size() != 0) begin
      chk("drain_pending", exp_re.size(), 0);
      exp_re.delete();
      exp_im.delete();
      iss.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    raw(1'b0, 32'h0, 1'b1);
    raw(1'b0, 32'h0, 1'b0);
    chk("rst_dv_out", int'(dv_out), 0);
    chk("rst_real", int'($signed(real_out)), 0);
    chk("rst_imag", int'($signed(imag_out)), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    dv_in = 1'b0;
    freq  = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("init_dv_out", int'(dv_out), 0);
    chk("init_real", int'($signed(real_out)), 0);
    chk("init_imag", int'($signed(imag_out)), 0);
    reset = 1'b0;

    // Quarter-turn steps: axis points, repeating after four samples.
    for (int n = 0; n < 8; n++) begin
      case (n % 4)
        0: strobe(32'h4000_0000, 31, 0);
        1: strobe(32'h4000_0000, 0, 31);
        2: strobe(32'h4000_0000, -31, 0);
        default: strobe(32'h4000_0000, 0, -31);
      endcase
      idle(4);
    end
    drain();
    idle(3);
    chk("hold_real", int'($signed(real_out)), 0);
    chk("hold_imag", int'($signed(imag_out)), -31);

    // Small steps, then a frequency change: idle freq is ignored, new word applies after.
    do_reset();
    strobe(32'h0123_4567, 31, 0);
    idle(15);
    strobe(32'h0123_4567, 31, 1);
    idle(15);
    strobe(32'h0123_4567, 31, 2);
    idle(2);
    freq = 32'hFFFF_FFFF;
    idle(13);
    strobe(32'h0446_8ACE, 31, 2);
    idle(15);
    strobe(32'h0446_8ACE, 31, 5);
    idle(15);

    // Half-turn steps at full rate.
    do_reset();
    for (int n = 0; n < 8; n++) begin
      if (n % 2 == 0) strobe(32'h8000_0000, 31, 0);
      else            strobe(32'h8000_0000, -31, 0);
    end
    idle(6);

    // Eighth-turn steps at full rate: diagonals in all quadrants.
    do_reset();
    strobe(32'h2000_0000, 31, 0);
    strobe(32'h2000_0000, 22, 22);
    strobe(32'h2000_0000, 0, 31);
    strobe(32'h2000_0000, -22, 22);
    strobe(32'h2000_0000, -31, 0);
    strobe(32'h2000_0000, -22, -22);
    strobe(32'h2000_0000, 0, -31);
    strobe(32'h2000_0000, 22, -22);
    idle(6);

    // k step 77: off-axis points in every quadrant (k = 0, 77, 154, 231, 52).
    do_reset();
    strobe(32'h4D00_0000, 31, 0);
    strobe(32'h4D00_0000, -10, 29);
    idle(2);
    strobe(32'h4D00_0000, -25, -18);
    strobe(32'h4D00_0000, 25, -18);
    strobe(32'h4D00_0000, 9, 30);
    idle(6);
    drain();
    idle(2);
    chk("hold_real2", int'($signed(real_out)), 9);
    chk("hold_imag2", int'($signed(imag_out)), 30);

    // Reset with samples in flight (and dv_in high during reset): all discarded.
    do_reset();
    strobe(32'h4000_0000, 31, 0);
    idle(5);
    drain();
    raw(1'b1, 32'h4000_0000, 1'b0);
    raw(1'b1, 32'h4000_0000, 1'b0);
    raw(1'b1, 32'h4000_0000, 1'b1);
    raw(1'b0, 32'h4000_0000, 1'b0);
    chk("midrst_real", int'($signed(real_out)), 0);
    chk("midrst_imag", int'($signed(imag_out)), 0);
    idle(6);
    chk("midrst_dv_out", int'(dv_out), 0);
    chk("midrst_real_late", int'($signed(real_out)), 0);
    strobe(32'h4000_0000, 31, 0);
    idle(6);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/emu_doppler_nco.md
Name: emu_doppler_nco

Overview:
Emulator Doppler numerically controlled oscillator in the GPS synthesizer datapath. Each valid strobe advances a 32-bit phase accumulator by a programmable frequency word and emits one complex carrier sample. Samples are 6-bit signed real (cosine) and imaginary (sine) components. Downstream blocks mix these samples with the synthesized GPS signal to impose Doppler shift.

Parameters:
None. The module is not parameterized; widths and constants are fixed, package-level values.

Ports:
clk       in   1   system clock; all logic on the rising edge
reset     in   1   synchronous, active-high reset
dv_in     in   1   sample strobe; one sample is produced per cycle it is high
freq      in   32  unsigned phase increment per sample, in units of 2^-32 cycle/sample; sampled only when dv_in=1
dv_out    out  1   output sample valid, single-cycle pulse per dv_in pulse
real_out  out  6   signed two's-complement cosine sample
imag_out  out  6   signed two's-complement sine sample

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Phase accumulator: 32-bit register phase.
  - Reset value 0.
  - On a cycle with dv_in=1, the current phase is used for this sample, and phase <= phase + freq (mod 2^32, natural wrap, no saturation).
  - When dv_in=0, phase holds.
- Sample n (0-based after reset) uses phase = sum of freq over samples 0..n-1. The first sample after reset is at phase 0.
- Address: k = phase[31:24], which is 256 points per cycle. Lower bits are truncated, with no dither.
- Output values:
  - real = round(31*cos(2*pi*k/256)), imag = round(31*sin(2*pi*k/256)).
  - Rounding is half away from zero.
  - The range is -31..+31; the value -32 never occurs.
- Table: implement as a 64-entry quarter-wave ROM of 5-bit magnitudes for k=0..63 (entry 0 = 0, growing to 31). Use quadrant folding (k[7:6]) with sign logic to build both outputs. For k[5:0]=0, the folded index must select the exact axis values 0 and 31.
- Pipeline, fixed latency of 3 cycles:
  - Stage 1: capture k; update the accumulator.
  - Stage 2: quadrant fold and ROM reads.
  - Stage 3: apply sign; register the outputs.
- dv_out equals dv_in delayed by exactly 3 cycles. Back-to-back dv_in (every cycle) is supported at full rate.
- real_out and imag_out update only when dv_out is asserted and hold their last value otherwise.
- Reset:
  - phase, all pipeline valids, dv_out, real_out and imag_out go to 0.
  - Samples in flight are discarded; no dv_out is produced for them.
  - Reset dominates dv_in in the same cycle.
- freq changes while dv_in=0 have no effect until the next strobe.

Decomposition:
- Package emu_doppler_nco_pkg holds:
  - constants PHASE_W=32, ADDR_W=8, OUT_W=6, AMP=31, LATENCY=3;
  - typedef of the 6-bit signed sample;
  - the 64-entry quarter-wave magnitude table as a constant array.
- One natural sub-module: emu_doppler_nco_lut. It takes the 8-bit phase address and returns registered signed cos/sin, covering pipeline stages 2-3.
- The top level holds the accumulator, stage 1 and the valid delay line.

Test Plan:
- Reset, then dv_in pulses with freq=0x40000000 -> dv_out exactly 3 cycles after each pulse; (real,imag) = (31,0), (0,31), (-31,0), (0,-31), then repeats.
- freq=0x01234567, pulse every 16 cycles from reset -> first three samples (31,0), (31,1), (31,2) for k=0x00, 0x01, 0x02.
- Then switch freq to 0x04468ace on a later strobe -> the next sample still uses the already-accumulated phase; the one after advances k by 4 (e.g. from k=0: (31,0) then (31,3)).
- freq=0x80000000, dv_in held high for 8 cycles -> dv_out high for 8 consecutive cycles; outputs alternate (31,0)/(-31,0).
- freq=0x20000000 -> samples include (22,22) at k=32 and (-22,-22) at k=160; no output ever equals -32.
- Assert reset mid-stream with samples in flight -> no dv_out afterwards; outputs read 0; the next strobe yields (31,0).
